// File: rtl/core_cache_fill.sv
// core_cache_fill
// Line-fill engine for the core cache. A miss fetches one whole line with a
// single burst read. Each returned word is written into the data SRAM, and the
// line's {valid, tag} entry is then written into the tag SRAM. A flush clears
// every tag entry by sweeping all indexes. This block is the only driver of the
// cache SRAM write ports.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_miss_valid/i_miss_addr  fill request (byte address of the missing word)
//   o_miss_ready              request accepted when valid && ready
//   i_flush                   invalidate-all level, sampled only in IDLE
//   o_mem_*/i_mem_*           burst read master (address, read, burstcount,
//                             waitrequest, readdata, readdatavalid)
//   o_data_*                  data SRAM write port {index, beat}
//   o_tag_*                   tag SRAM write port {valid, tag}
//   o_fill_done/o_flush_done  one-cycle completion pulses
module core_cache_fill #(
  parameter int line_words = 4,
  parameter int index_bits = 6,
  localparam int OB        = $clog2(line_words),
  localparam int TAG_BITS  = 32 - 2 - OB - index_bits
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_miss_valid,
  input  logic [31:0]              i_miss_addr,
  output logic                     o_miss_ready,
  input  logic                     i_flush,
  output logic [31:0]              o_mem_address,
  output logic                     o_mem_read,
  output logic [OB:0]              o_mem_burstcount,
  input  logic                     i_mem_waitrequest,
  input  logic [31:0]              i_mem_readdata,
  input  logic                     i_mem_readdatavalid,
  output logic [index_bits+OB-1:0] o_data_wraddress,
  output logic                     o_data_wren,
  output logic [31:0]              o_data_data,
  output logic [index_bits-1:0]    o_tag_wraddress,
  output logic                     o_tag_wren,
  output logic [TAG_BITS:0]        o_tag_data,
  output logic                     o_fill_done,
  output logic                     o_flush_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RECV  = 3'd2,
    DONE  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  localparam logic [OB-1:0]         BEAT_LAST  = OB'(line_words - 1);
  localparam logic [index_bits-1:0] FLUSH_LAST = '1;

  state_t                    r_state;
  state_t                    w_state_next;
  logic                      w_accept;
  logic [TAG_BITS-1:0]       r_tag;
  logic [index_bits-1:0]     r_index;
  logic [OB-1:0]             r_beat;
  logic [index_bits-1:0]     r_flush_idx;
  logic                      r_data_wren;
  logic [index_bits+OB-1:0]  r_data_wraddress;
  logic [31:0]               r_data_data;

  // Byte-select and word-offset bits do not matter for a whole-line fill.
  logic [OB+1:0] w_unused_addr_bits;
  assign w_unused_addr_bits = i_miss_addr[OB+1:0];

  // Next-state logic. Flush wins over a simultaneous miss in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_flush) begin
          w_state_next = FLUSH;
        end else if (i_miss_valid) begin
          w_state_next = REQ;
          w_accept     = 1'b1;
        end
      end
      REQ:   if (!i_mem_waitrequest) w_state_next = RECV;
      RECV:  if (i_mem_readdatavalid && (r_beat == BEAT_LAST)) w_state_next = DONE;
      DONE:  w_state_next = IDLE;
      FLUSH: if (r_flush_idx == FLUSH_LAST) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= IDLE;
      r_tag            <= '0;
      r_index          <= '0;
      r_beat           <= '0;
      r_flush_idx      <= '0;
      r_data_wren      <= 1'b0;
      r_data_wraddress <= '0;
      r_data_data      <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_tag   <= i_miss_addr[31 -: TAG_BITS];
        r_index <= i_miss_addr[OB+2 +: index_bits];
      end

      if (r_state == REQ && !i_mem_waitrequest) begin
        r_beat <= '0;
      end else if (r_state == RECV && i_mem_readdatavalid) begin
        r_beat <= r_beat + 1'b1;
      end

      // Sweep counter wraps back to zero naturally after the last index.
      if (r_state == FLUSH) begin
        r_flush_idx <= r_flush_idx + 1'b1;
      end else begin
        r_flush_idx <= '0;
      end

      // Beats are written one cycle after they arrive; beats outside RECV
      // (stray or left over from an abandoned burst) are dropped.
      r_data_wren <= (r_state == RECV) && i_mem_readdatavalid;
      if (r_state == RECV && i_mem_readdatavalid) begin
        r_data_wraddress <= {r_index, r_beat};
        r_data_data      <= i_mem_readdata;
      end
    end
  end

  assign o_miss_ready     = (r_state == IDLE) && !i_flush;
  assign o_mem_read       = (r_state == REQ);
  assign o_mem_address    = (r_state == REQ) ? {r_tag, r_index, {(OB+2){1'b0}}} : 32'd0;
  assign o_mem_burstcount = (OB+1)'(line_words);

  assign o_data_wren      = r_data_wren;
  assign o_data_wraddress = r_data_wraddress;
  assign o_data_data      = r_data_data;

  always_comb begin
    o_tag_wren      = 1'b0;
    o_tag_wraddress = '0;
    o_tag_data      = '0;
    case (r_state)
      DONE: begin
        o_tag_wren      = 1'b1;
        o_tag_wraddress = r_index;
        o_tag_data      = {1'b1, r_tag};
      end
      FLUSH: begin
        o_tag_wren      = 1'b1;
        o_tag_wraddress = r_flush_idx;
      end
      default: ;
    endcase
  end

  assign o_fill_done  = (r_state == DONE);
  assign o_flush_done = (r_state == FLUSH) && (r_flush_idx == FLUSH_LAST);

endmodule

// File: doc/core_cache_fill.md
# core_cache_fill

Line-fill engine for the core cache. On a miss it fetches one full cache line from memory with a single burst read. It writes each returned word into the cache data SRAM and then writes the line's tag/valid entry into the tag SRAM. It also performs a full-cache invalidate (flush) by sweeping the tag SRAM. The block sits directly upstream of the cache SRAM write ports (`wraddress`/`wren`/`data`) and drives them exclusively.

## Interface
Parameters:
- `line_words`, 4: words per line; power of 2, at least 2; `ob` = log2(`line_words`).
- `index_bits`, 6: line-index width; number of lines = 2^`index_bits`.
- Derived: `tag_bits` = 32 − 2 − `ob` − `index_bits` (22 at defaults).

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `miss_valid`  in  1  fill request.
- `miss_addr`  in  32  byte address of the missing word.
- `miss_ready`  out  1  request accepted when `miss_valid` && `miss_ready`.
- `flush`  in  1  invalidate-all request; a level, sampled only in IDLE.
- `mem_address`  out  32  line-aligned byte address of the burst.
- `mem_read`  out  1  burst read command.
- `mem_burstcount`  out  `ob`+1  constant `line_words`.
- `mem_waitrequest`  in  1  command stall.
- `mem_readdata`  in  32  returned word.
- `mem_readdatavalid`  in  1  beat valid.
- `data_wraddress`  out  `index_bits`+`ob`  data SRAM write address {index, beat}.
- `data_wren`  out  1  data SRAM write enable.
- `data_data`  out  32  data SRAM write data.
- `tag_wraddress`  out  `index_bits`  tag SRAM write address.
- `tag_wren`  out  1  tag SRAM write enable.
- `tag_data`  out  `tag_bits`+1  {valid, tag}.
- `fill_done`  out  1  one-cycle pulse when a fill completes.
- `flush_done`  out  1  one-cycle pulse when a flush completes.

## Operation
- Address split of `miss_addr`:
  - tag = [31:32−`tag_bits`]
  - index = [`ob`+1+`index_bits`:`ob`+2], i.e. the `index_bits` bits above the offset
  - offset = [`ob`+1:2]
  - On acceptance, tag and index are latched.
- States: IDLE, REQ, RECV, DONE, FLUSH.
- IDLE:
  - `miss_ready` = !`flush` (combinational).
  - If `flush` is high, go to FLUSH; flush has priority and no miss is accepted that cycle.
  - Else, on `miss_valid`, latch the address and go to REQ.
- REQ:
  - `mem_read`=1 and `mem_address`={tag, index, `ob`+2 zero bits}.
  - Address and command are held stable while `mem_waitrequest`=1.
  - When `mem_waitrequest`=0, go to RECV with beat counter = 0.
- RECV:
  - Each `mem_readdatavalid` registers a data write for the next cycle: `data_wren`=1, `data_wraddress`={index, beat}, `data_data`=`mem_readdata`. The beat counter then increments.
  - The beat with counter = `line_words`−1 is the last beat and transitions to DONE.
  - Beats may be non-contiguous. `mem_readdatavalid` in any other state is ignored.
- DONE (one cycle):
  - The final data write is presented.
  - `tag_wren`=1, `tag_wraddress`=index, `tag_data`={1, tag}.
  - `fill_done`=1, then go to IDLE.
- FLUSH:
  - Counter `i` runs from 0 to 2^`index_bits`−1.
  - Each cycle: `tag_wren`=1, `tag_wraddress`=`i`, `tag_data`=0.
  - On the last index, `flush_done`=1 in the same cycle, then go to IDLE.
  - `flush` deasserting mid-sweep does not abort the sweep.
- No cancellation: once accepted, a fill always completes.
- `data_wren` and `tag_wren` are never asserted in the same cycle except in DONE.

## Timing
- Reset (async assert, sync release):
  - State IDLE, all counters 0.
  - `mem_read`, `data_wren`, `tag_wren`, `fill_done`, `flush_done` = 0.
  - `mem_address`, `data_wraddress`, `data_data`, `tag_wraddress`, `tag_data` = 0.
  - `mem_burstcount` = `line_words` (constant).
  - `miss_ready` = !`flush`.
- Reset mid-fill or mid-flush: the operation is abandoned. No further SRAM writes occur, and beats still arriving from the old burst after reset are ignored.
- Miss accepted at edge 0: `mem_read` is high from cycle 1.
- With zero wait and beats returning on cycles c..c+`line_words`−1: data writes occur on c+1..c+`line_words`, and DONE (tag write, `fill_done`) is cycle c+`line_words`.
- `miss_ready` returns high at c+`line_words`+1.
- Flush takes exactly 2^`index_bits` cycles of `tag_wren`. IDLE follows on the next cycle.

## Test plan
- Basic fill (defaults):
  - Stimulus: miss at 0x0000_1234; `mem_waitrequest`=0; beats 0xA0..0xA3 on consecutive cycles.
  - Response: `mem_address`=0x0000_1230, `mem_burstcount`=4; data writes to addresses 0x8C..0x8F with 0xA0..0xA3; tag write at index 0x23, `tag_data`={1,0x000004}; one `fill_done` pulse.
- Waitrequest and gappy beats:
  - Stimulus: `mem_waitrequest` high for 3 cycles; beats separated by idle cycles.
  - Response: `mem_address` is stable throughout; exactly 4 data writes, each one cycle after its beat; no extra writes in the gaps.
- Flush vs miss:
  - Stimulus: `flush` and `miss_valid` asserted together in IDLE.
  - Response: `miss_ready`=0; 64 tag writes to indexes 0..63 with `tag_data`=0; `flush_done` on index 63; the miss is accepted afterwards.
- Stray beats:
  - Stimulus: `mem_readdatavalid` pulsed in IDLE and in REQ.
  - Response: no data or tag writes.
- Reset mid-fill:
  - Stimulus: `rst_n` low after beat 1, then released while the remaining beats arrive.
  - Response: all outputs reset immediately; only 2 data writes total; no tag write and no `fill_done`; `miss_ready`=1.
- Back-to-back:
  - Stimulus: `miss_valid` held high with a new address.
  - Response: the second miss is accepted the cycle after DONE; the second burst `mem_read` follows on the next cycle.
